// File: rtl/scancode_key_decoder.sv
// PS/2 Set 2 scancode parser: tracks break/extended prefixes and shift state,
// maps make codes to ASCII and queues them in a show-ahead FIFO.
module scancode_key_decoder #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CASE_MODE    = 0,
  parameter int unsigned PASS_UNKNOWN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] ascii_code,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_held
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  state_t        r_state;
  logic          r_shift;
  logic          r_overflow;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic       w_letter;
  logic [4:0] w_idx;
  logic       w_known;
  logic [7:0] w_char;
  logic       w_is_shift;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_do_push;

  always_comb begin
    w_letter = 1'b1;
    w_idx    = '0;
    case (scan_code)
      8'h1C: w_idx = 5'd0;   8'h32: w_idx = 5'd1;   8'h21: w_idx = 5'd2;
      8'h23: w_idx = 5'd3;   8'h24: w_idx = 5'd4;   8'h2B: w_idx = 5'd5;
      8'h34: w_idx = 5'd6;   8'h33: w_idx = 5'd7;   8'h43: w_idx = 5'd8;
      8'h3B: w_idx = 5'd9;   8'h42: w_idx = 5'd10;  8'h4B: w_idx = 5'd11;
      8'h3A: w_idx = 5'd12;  8'h31: w_idx = 5'd13;  8'h44: w_idx = 5'd14;
      8'h4D: w_idx = 5'd15;  8'h15: w_idx = 5'd16;  8'h2D: w_idx = 5'd17;
      8'h1B: w_idx = 5'd18;  8'h2C: w_idx = 5'd19;  8'h3C: w_idx = 5'd20;
      8'h2A: w_idx = 5'd21;  8'h1D: w_idx = 5'd22;  8'h22: w_idx = 5'd23;
      8'h35: w_idx = 5'd24;  8'h1A: w_idx = 5'd25;
      default: w_letter = 1'b0;
    endcase
  end

  always_comb begin
    w_known = 1'b1;
    w_char  = '0;
    case (scan_code)
      8'h45: w_char = 8'h30;  8'h16: w_char = 8'h31;  8'h1E: w_char = 8'h32;
      8'h26: w_char = 8'h33;  8'h25: w_char = 8'h34;  8'h2E: w_char = 8'h35;
      8'h36: w_char = 8'h36;  8'h3D: w_char = 8'h37;  8'h3E: w_char = 8'h38;
      8'h46: w_char = 8'h39;
      8'h5A: w_char = 8'h0D;  8'h29: w_char = 8'h20;  8'h66: w_char = 8'h08;
      default: begin
        w_known = w_letter;
        w_char  = (CASE_MODE == 0 || r_shift) ? 8'h41 + {3'b000, w_idx}
                                              : 8'h61 + {3'b000, w_idx};
      end
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_data = w_char;
    w_is_shift  = (scan_code == 8'h12) || (scan_code == 8'h59);
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code != 8'hF0 && scan_code != 8'hE0 && !w_is_shift) begin
            if (w_known) begin
              w_push = 1'b1;
            end else if (PASS_UNKNOWN != 0) begin
              w_push      = 1'b1;
              w_push_data = scan_code;
            end
          end
        end
        ST_EXT: begin
          if (scan_code == 8'h5A) begin
            w_push      = 1'b1;
            w_push_data = 8'h0D;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= 1'b0;
    end else if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code == 8'hF0)      r_state <= ST_BRK;
          else if (scan_code == 8'hE0) r_state <= ST_EXT;
          else if (w_is_shift)         r_shift <= 1'b1;
        end
        ST_BRK: begin
          if (w_is_shift) r_shift <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_EXT:     r_state <= (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && ascii_ready;
  assign w_do_push = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign ascii_code  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign ascii_valid = !w_empty;
  assign fifo_full   = w_full;
  assign overflow    = r_overflow;
  assign shift_held  = r_shift;

endmodule
